if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core; feeds decode and the hazard unit.
//  Owns PCF, drives a req/ready instruction-memory port, and applies StallF/StallD and PCSrcD redirects.
//  Absorbs variable memory latency; reports fetch-side stalls on FetchStallF.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  NOP_INSTR  32'h0000_0000  bubble written to InstrD on flush/reset
// PORTS
//  clk         in   1   sole clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  StallF      in   1   hold PCF (hazard unit)
//  StallD      in   1   hold IF/ID register (hazard unit)
//  PCSrcD      in   2   0 seq, 1 branch (PCBranchD), 2 jump (PCJumpD), 3 jr (PCJrD)
//  PCBranchD   in   32  branch target
//  PCJumpD     in   32  jump target
//  PCJrD       in   32  register-jump target
//  imem_req    out  1   fetch request; held with stable imem_addr until imem_ready
//  imem_addr   out  32  word address, bits[1:0] forced 00
//  imem_ready  in   1   response strobe; imem_rdata valid this cycle
//  imem_rdata  in   32  instruction word
//  InstrD      out  32  IF/ID instruction
//  PCPlus4D    out  32  IF/ID PC+4
//  ValidD      out  1   IF/ID holds a real instruction
//  FetchStallF out  1   no instruction available to load into IF/ID this cycle
//  FetchCnt    out  32  instructions delivered (see CONFIGURATION)
//  KillCnt     out  32  responses discarded by redirect (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, imem_req=0, FetchStallF=0, hold empty, state IDLE.
//  - States: IDLE -> FETCH unconditionally next cycle.
//    FETCH: imem_req=1, imem_addr=req_addr (latched from PCF on entry).
//      ready & !StallD: load IF/ID {rdata, req_addr+4, 1}; PCF<=req_addr+4 unless StallF; stay FETCH (1 instr/cycle at zero wait).
//      ready & StallD: capture into hold buffer -> HOLD, imem_req=0.
//      !ready: FetchStallF=1, stay.
//    HOLD: imem_req=0; when StallD drops, hold -> IF/ID, next cycle FETCH.
//    KILL: redirect occurred while FETCH outstanding; imem_req stays high, addr unchanged; FetchStallF=1; on ready, discard data -> FETCH at PCF.
//  - Redirect (PCSrcD!=0): PCF<=target & ~3; IF/ID<= {NOP_INSTR,0,0}; hold invalidated. Overrides StallD and StallF.
//    From FETCH: ready same cycle -> discard, next FETCH at target; not ready -> KILL.
//    From HOLD -> FETCH; from KILL -> stay KILL with the new target.
//  - PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
//  - Request handshake: imem_addr never changes while imem_req=1 and imem_ready=0.
//  - rst mid-transaction: state forced IDLE, outstanding response ignored. Memory must drop the request on rst.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: FetchCnt counts IF/ID loads with ValidD=1; KillCnt counts discarded responses.
//    Both counters reset to 0 and wrap.
//  IF_PERF_CNT_EN undefined: both ports tied to 0, no counter flops.
// STRUCTURE
//  Shared package pipe_pkg: PCSrc encodings (PCSRC_SEQ/BR/J/JR), NOP constant, fetch state enum {IDLE,FETCH,HOLD,KILL}.
//  One sub-module: if_hold_buf (1-entry instr/PC+4 buffer, load/drain/clear).
//  FSM, PC mux and IF/ID register stay in this module.
// TESTING
//  1 zero-wait memory, no stalls, 4 cycles after reset: InstrD from addr 0,4,8,C; ValidD=1 from the 3rd cycle.
//  2 ready delayed 3 cycles at PCF=0x40: imem_addr stable 0x40, FetchStallF=1 for 3 cycles, then PCPlus4D=0x44.
//  3 PCSrcD=1, PCBranchD=0x100 while a request is outstanding:
//    KILL; late data discarded; next imem_addr=0x100; KillCnt=1 (macro on).
//  4 StallD=1 for 2 cycles during a ready:
//    InstrD unchanged; on release InstrD=held word, no duplicate or lost fetch.
//  5 PCSrcD=3, PCJrD=0x203 with StallD=1 in the same cycle: ValidD=0, InstrD=NOP, next imem_addr=0x200.
//  6 PCF=0xFFFFFFFC fetched: PCPlus4D=0, next imem_addr=0. rst mid-FETCH: all outputs at reset values next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC-source encodings, bubble instruction, fetch FSM states.
package pipe_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_J   = 2'd2,
        PCSRC_JR  = 2'd3
    } pcsrc_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        KILL
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready port; the fetch stage is the master.
interface if_fetch_stage_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, rdata);
    modport slave  (input req, addr, output ready, rdata);

endinterface

// File: rtl/if_hold_buf.sv
// One-entry instruction/PC+4 buffer that parks a response while decode is stalled.
module if_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc_plus4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // NOTE: payload flops carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        if (load) begin
            instr    <= next_instr;
            pc_plus4 <= next_pc_plus4;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS fetch stage and IF/ID register with variable-latency imem port.
// Define IF_PERF_CNT_EN to build the FetchCnt/KillCnt performance counters.
module if_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     StallF,
    input  logic                     StallD,
    input  logic [1:0]               PCSrcD,
    input  logic [31:0]              PCBranchD,
    input  logic [31:0]              PCJumpD,
    input  logic [31:0]              PCJrD,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              InstrD,
    output logic [31:0]              PCPlus4D,
    output logic                     ValidD,
    output logic                     FetchStallF,
    output logic [31:0]              FetchCnt,
    output logic [31:0]              KillCnt
);

    fetch_state_e state, state_next;
    pcsrc_e       pcsrc;
    logic [31:0]  pcf, pc_next, req_addr, req_plus4, redirect_target;
    logic         redirect, req, fetch_load, capture, drain;
    logic         hold_valid;
    logic [31:0]  hold_instr, hold_pc_plus4;

    assign pcsrc     = pcsrc_e'(PCSrcD);
    assign redirect  = (pcsrc != PCSRC_SEQ);
    assign req_plus4 = req_addr + 32'd4;
    assign imem.req  = req;
    assign imem.addr = word_align(req_addr);

    always_comb begin
        unique case (pcsrc)
            PCSRC_BR:  redirect_target = word_align(PCBranchD);
            PCSRC_J:   redirect_target = word_align(PCJumpD);
            PCSRC_JR:  redirect_target = word_align(PCJrD);
            PCSRC_SEQ: redirect_target = pcf;
        endcase
    end

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_next  = state;
        pc_next     = pcf;
        req         = 1'b0;
        FetchStallF = 1'b0;
        fetch_load  = 1'b0;
        capture     = 1'b0;
        drain       = 1'b0;
        unique case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                req         = 1'b1;
                FetchStallF = !imem.ready;
                if (imem.ready) begin
                    if (redirect) begin
                        state_next = FETCH;
                    end else if (StallD) begin
                        // PC moves past the parked word so the refetch after HOLD is not a duplicate
                        capture    = 1'b1;
                        pc_next    = req_plus4;
                        state_next = HOLD;
                    end else begin
                        fetch_load = 1'b1;
                        if (!StallF) pc_next = req_plus4;
                    end
                end else if (redirect) begin
                    state_next = KILL;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_next = FETCH;
                end else if (!StallD) begin
                    drain      = 1'b1;
                    state_next = FETCH;
                end
            end
            KILL: begin
                req         = 1'b1;
                FetchStallF = 1'b1;
                if (imem.ready) state_next = FETCH;
            end
        endcase
        if (redirect) pc_next = redirect_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pcf      <= word_align(RESET_PC);
            req_addr <= word_align(RESET_PC);
        end else begin
            state <= state_next;
            pcf   <= pc_next;
            if (state_next == FETCH) req_addr <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (fetch_load) begin
                InstrD   <= imem.rdata;
                PCPlus4D <= req_plus4;
                ValidD   <= 1'b1;
            end else if (drain) begin
                InstrD   <= hold_instr;
                PCPlus4D <= hold_pc_plus4;
                ValidD   <= hold_valid;
            end else begin
                InstrD   <= NOP_INSTR;
                PCPlus4D <= 32'd0;
                ValidD   <= 1'b0;
            end
        end
    end

    if_hold_buf u_hold_buf (
        .clk           (clk),
        .rst           (rst),
        .load          (capture),
        .drain         (drain),
        .clear         (redirect),
        .next_instr    (imem.rdata),
        .next_pc_plus4 (req_plus4),
        .valid         (hold_valid),
        .instr         (hold_instr),
        .pc_plus4      (hold_pc_plus4)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, kill_cnt;
    logic        discard;

    assign discard = imem.ready && ((state == KILL) || (state == FETCH && redirect));

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
            kill_cnt  <= 32'd0;
        end else begin
            if (fetch_load || (drain && hold_valid)) fetch_cnt <= fetch_cnt + 32'd1;
            if (discard) kill_cnt <= kill_cnt + 32'd1;
        end
    end

    assign FetchCnt = fetch_cnt;
    assign KillCnt  = kill_cnt;
`else
    assign FetchCnt = 32'd0;
    assign KillCnt  = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: credit-driven memory model, decoupled IF/ID monitor.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic [1:0]  PCSrcD = 2'd0;
    logic [31:0] PCBranchD = 32'd0;
    logic [31:0] PCJumpD = 32'd0;
    logic [31:0] PCJrD = 32'd0;
    logic [31:0] InstrD, PCPlus4D, FetchCnt, KillCnt;
    logic        ValidD, FetchStallF;

    if_fetch_stage_if imem ();

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .StallD      (StallD),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .PCJumpD     (PCJumpD),
        .PCJrD       (PCJrD),
        .imem        (imem),
        .InstrD      (InstrD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD),
        .FetchStallF (FetchStallF),
        .FetchCnt    (FetchCnt),
        .KillCnt     (KillCnt)
    );

    always #5 clk = ~clk;

`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          credits = 0;
    int          mem_wait = 0;
    int          mem_cnt = 0;
    int          n_pushed = 0;
    logic        stall_last = 1'b1;
    logic        pend_last = 1'b0;
    logic [31:0] addr_last = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.instr    = mem_word(a);
        e.pc_plus4 = a + 32'd4;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic wait_served(input string name);
        int n = 0;
        while (credits != 0 && n < 100) begin
            next_cycle();
            n++;
        end
        total++;
        if (credits != 0) begin
            bad++;
            $display("FAIL %s: timeout with %0d responses unconsumed, want 0", name, credits);
        end
    endtask

    // Memory: answers the held request after mem_wait cycles while credits remain.
    initial begin
        imem.ready = 1'b0;
        imem.rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #2;
            imem.ready = 1'b0;
            imem.rdata = 32'hDEAD_BEEF;
            if (rst) begin
                mem_cnt = 0;
                credits = 0;
            end else if (imem.req && credits > 0) begin
                if (mem_cnt >= mem_wait) begin
                    imem.ready = 1'b1;
                    imem.rdata = mem_word(imem.addr);
                    credits--;
                    mem_cnt = 0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Monitor: every fresh valid IF/ID load is matched against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !stall_last && ValidD) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got instr %h pc4 %h, want none", InstrD, PCPlus4D);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_instr", InstrD, e.instr);
                    check("sb_pc_plus4", PCPlus4D, e.pc_plus4);
                end
            end
            if (!rst && pend_last && imem.req) check("req_addr_stable", imem.addr, addr_last);
            stall_last = StallD || rst;
            pend_last  = imem.req && !imem.ready && !rst;
            addr_last  = imem.addr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_instr", InstrD, 32'h0000_0000);
        check("rst_pc_plus4", PCPlus4D, 32'd0);
        check("rst_valid", ValidD, 1'b0);
        check("rst_req", imem.req, 1'b0);
        check("rst_fetch_stall", FetchStallF, 1'b0);
        check("rst_fetch_cnt", FetchCnt, 32'd0);
        check("rst_kill_cnt", KillCnt, 32'd0);

        // Zero-wait stream from reset
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        credits = 4;
        next_cycle();
        @(negedge clk);
        check("t1_first_addr", imem.addr, 32'h0);
        check("t1_valid_cyc2", ValidD, 1'b0);
        next_cycle();
        @(negedge clk);
        check("t1_valid_cyc3", ValidD, 1'b1);
        wait_served("t1_serve");

        // Walk up to 0x40, then a three-cycle wait state
        for (int a = 16; a < 64; a += 4) push_exp(32'(a));
        credits = 12;
        wait_served("t2_seq");
        mem_wait = 3;
        credits  = 1;
        push_exp(32'h40);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_wait_stall", FetchStallF, 1'b1);
            check("t2_wait_addr", imem.addr, 32'h40);
            next_cycle();
        end
        @(negedge clk);
        check("t2_ready_stall", FetchStallF, 1'b0);
        next_cycle();
        mem_wait = 0;
        @(negedge clk);
        check("t2_pc_plus4", PCPlus4D, 32'h44);

        // Branch while 0x44 is outstanding
        next_cycle();
        PCSrcD    = 2'd1;
        PCBranchD = 32'h100;
        next_cycle();
        PCSrcD = 2'd0;
        @(negedge clk);
        check("t3_kill_stall", FetchStallF, 1'b1);
        check("t3_kill_addr", imem.addr, 32'h44);
        check("t3_kill_valid", ValidD, 1'b0);
        push_exp(32'h100);
        credits = 2;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("t3_target_addr", imem.addr, 32'h100);
        next_cycle();
        @(negedge clk);
        check("t3_kill_cnt", KillCnt, PERF ? 32'd1 : 32'd0);

        // Decode stall across a returning response
        next_cycle();
        push_exp(32'h104);
        push_exp(32'h108);
        credits = 2;
        next_cycle();
        StallD = 1'b1;
        StallF = 1'b1;
        @(negedge clk);
        check("t4_valid", ValidD, 1'b1);
        next_cycle();
        @(negedge clk);
        check("t4_held_instr", InstrD, mem_word(32'h104));
        check("t4_hold_req", imem.req, 1'b0);
        next_cycle();
        StallD = 1'b0;
        StallF = 1'b0;
        @(negedge clk);
        check("t4_release_instr", InstrD, mem_word(32'h104));
        next_cycle();
        @(negedge clk);
        check("t4_drained_instr", InstrD, mem_word(32'h108));
        check("t4_next_addr", imem.addr, 32'h10C);

        // jr with an unaligned target plus StallD in the same cycle
        next_cycle();
        push_exp(32'h10C);
        credits = 2;
        next_cycle();
        PCSrcD = 2'd3;
        PCJrD  = 32'h203;
        StallD = 1'b1;
        StallF = 1'b1;
        next_cycle();
        PCSrcD = 2'd0;
        StallD = 1'b0;
        StallF = 1'b0;
        @(negedge clk);
        check("t5_valid", ValidD, 1'b0);
        check("t5_instr", InstrD, 32'h0000_0000);
        check("t5_addr", imem.addr, 32'h200);
        check("t5_kill_cnt", KillCnt, PERF ? 32'd2 : 32'd0);

        // Jump to the top word: PC+4 wraps to zero
        next_cycle();
        PCSrcD  = 2'd2;
        PCJumpD = 32'hFFFF_FFFF;
        next_cycle();
        PCSrcD = 2'd0;
        push_exp(32'hFFFF_FFFC);
        credits = 2;
        wait_served("t6_serve");
        @(negedge clk);
        check("t6_wrap_pc_plus4", PCPlus4D, 32'd0);
        check("t6_wrap_valid", ValidD, 1'b1);
        check("t6_wrap_addr", imem.addr, 32'd0);

        // Reset while a fetch of 0x4 is in flight
        next_cycle();
        push_exp(32'h0);
        credits = 1;
        next_cycle();
        StallD   = 1'b1;
        mem_wait = 3;
        credits  = 1;
        @(negedge clk);
        check("cnt_fetch", FetchCnt, PERF ? 32'(n_pushed) : 32'd0);
        check("cnt_kill", KillCnt, PERF ? 32'd3 : 32'd0);
        check("pre_rst_pc_plus4", PCPlus4D, 32'h4);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst      = 1'b0;
        StallD   = 1'b0;
        mem_wait = 0;
        @(negedge clk);
        check("mid_rst_instr", InstrD, 32'h0000_0000);
        check("mid_rst_pc_plus4", PCPlus4D, 32'd0);
        check("mid_rst_valid", ValidD, 1'b0);
        check("mid_rst_req", imem.req, 1'b0);
        check("mid_rst_fetch_stall", FetchStallF, 1'b0);
        check("mid_rst_fetch_cnt", FetchCnt, 32'd0);
        check("mid_rst_kill_cnt", KillCnt, 32'd0);
        next_cycle();
        @(negedge clk);
        check("post_rst_req", imem.req, 1'b1);
        check("post_rst_addr", imem.addr, 32'h0);
        next_cycle();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
